// File: rtl/decode_pkg.sv
// Shared constants and helpers for the instruction-decode stage.
package decode_pkg;

  localparam int REG_N  = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Logical immediates are zero-extended; every other opcode sign-extends.
  function automatic logic uses_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus between fetch/writeback and the decode stage.
// The master drives the fetched word, pipeline control and the writeback port;
// the slave (decode_stage) returns the decoded fields and operands.
interface decode_stage_if #(parameter int DATA_W = 32);

  logic [31:0]       instr_in;
  logic [3:0]        pc_upper_in;
  logic              stall;
  logic              flush;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              valid;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [31:0]       imm_ext;
  logic [31:0]       jump_target;

  modport master (
    output instr_in, pc_upper_in, stall, flush, wb_we, wb_addr, wb_data,
    input  valid, opcode, rs, rt, rd, shamt, funct,
           rs_data, rt_data, imm_ext, jump_target
  );

  modport slave (
    input  instr_in, pc_upper_in, stall, flush, wb_we, wb_addr, wb_data,
    output valid, opcode, rs, rt, rd, shamt, funct,
           rs_data, rt_data, imm_ext, jump_target
  );

endinterface

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one synchronous write port, register 0 hard-wired to zero.
module reg_file
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] regs [REG_N];

  // Clear everything on reset (a coincident write is dropped); never write $0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // rs read: $0 is zero, a same-cycle write to rs is forwarded ahead of the array.
  always_comb begin
    rs_data = '0;
    if (rs_addr != '0) begin
      if (wr_en && (wr_addr == rs_addr)) begin
        rs_data = wr_data;
      end else begin
        rs_data = regs[rs_addr];
      end
    end
  end

  // rt read: same forwarding rule as rs.
  always_comb begin
    rt_data = '0;
    if (rt_addr != '0) begin
      if (wr_en && (wr_addr == rt_addr)) begin
        rt_data = wr_data;
      end else begin
        rt_data = regs[rt_addr];
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline register with flush/stall, field split,
// operand read, immediate extension and jump-target formation.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic           reloj,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  logic [31:0] instr_q;
  logic [3:0]  pcu_q;
  logic        valid_q;

  // IF/ID register: reset and flush insert a bubble, stall holds, else load.
  always_ff @(posedge reloj) begin
    if (reset || bus.flush) begin
      instr_q <= NOP_INSTR;
      pcu_q   <= '0;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      instr_q <= bus.instr_in;
      pcu_q   <= bus.pc_upper_in;
      valid_q <= 1'b1;
    end
  end

  assign bus.valid  = valid_q;
  assign bus.opcode = instr_q[31:26];
  assign bus.rs     = instr_q[25:21];
  assign bus.rt     = instr_q[20:16];
  assign bus.rd     = instr_q[15:11];
  assign bus.shamt  = instr_q[10:6];
  assign bus.funct  = instr_q[5:0];

  // Immediate extension selected by opcode; jump target formed unconditionally.
  always_comb begin
    bus.imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};
    if (uses_zero_ext(instr_q[31:26])) begin
      bus.imm_ext = {16'h0000, instr_q[15:0]};
    end
    bus.jump_target = {pcu_q, instr_q[25:0], 2'b00};
  end

  reg_file #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_reg_file (
    .clk     (reloj),
    .reset   (reset),
    .rs_addr (instr_q[25:21]),
    .rt_addr (instr_q[20:16]),
    .wr_en   (bus.wb_we),
    .wr_addr (bus.wb_addr),
    .wr_data (bus.wb_data),
    .rs_data (bus.rs_data),
    .rt_data (bus.rt_data)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed table, hand-written corner sequences,
// then randomized traffic against a behavioural model.
module tb_decode_stage;

  typedef struct packed {
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  pcu;
    logic        stall;
    logic        flush;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] jt;
  } outs_t;

  typedef struct packed {
    in_t   in;
    outs_t exp;
  } vec_t;

  logic reloj;
  logic reset;
  int   vectors;
  int   miscompares;

  decode_stage_if #(.DATA_W(32)) bus ();

  decode_stage #(.DATA_W(32), .REG_N(32)) dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  // Behavioural model state: architectural registers and the latched instruction.
  logic [31:0] m_regs [32];
  logic [31:0] m_instr;
  logic [3:0]  m_pcu;
  logic        m_valid;

  function automatic in_t mkIn(input logic r, input logic [31:0] i, input logic [3:0] p,
                               input logic s, input logic f, input logic w,
                               input logic [4:0] a, input logic [31:0] d);
    in_t v;
    v.rst = r; v.instr = i; v.pcu = p; v.stall = s; v.flush = f;
    v.we = w; v.addr = a; v.data = d;
    return v;
  endfunction

  function automatic outs_t mkOut(input logic v, input logic [5:0] op, input logic [4:0] s,
                                  input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                                  input logic [5:0] fn, input logic [31:0] sd, input logic [31:0] td,
                                  input logic [31:0] im, input logic [31:0] j);
    outs_t o;
    o.valid = v; o.opcode = op; o.rs = s; o.rt = t; o.rd = d; o.shamt = sh;
    o.funct = fn; o.rs_data = sd; o.rt_data = td; o.imm = im; o.jt = j;
    return o;
  endfunction

  task automatic modelEdge(input in_t v);
    if (v.rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_instr = 32'd0; m_pcu = 4'd0; m_valid = 1'b0;
    end else begin
      if (v.we && v.addr != 5'd0) m_regs[v.addr] = v.data;
      if (v.flush) begin
        m_instr = 32'd0; m_pcu = 4'd0; m_valid = 1'b0;
      end else if (!v.stall) begin
        m_instr = v.instr; m_pcu = v.pcu; m_valid = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] modelRead(input int a, input in_t v);
    if (a == 0) return 32'd0;
    if (v.we && int'(v.addr) == a) return v.data;
    return m_regs[a];
  endfunction

  function automatic outs_t modelOut(input in_t v);
    outs_t o;
    int unsigned w;
    int unsigned op;
    int unsigned lo;
    w  = m_instr;
    op = w / 32'h0400_0000;
    lo = w % 65536;
    o.valid   = m_valid;
    o.opcode  = 6'(op);
    o.rs      = 5'((w / (1 << 21)) % 32);
    o.rt      = 5'((w / (1 << 16)) % 32);
    o.rd      = 5'((w / (1 << 11)) % 32);
    o.shamt   = 5'((w / (1 << 6)) % 32);
    o.funct   = 6'(w % 64);
    o.rs_data = modelRead(int'(o.rs), v);
    o.rt_data = modelRead(int'(o.rt), v);
    if (op == 12 || op == 13 || op == 14 || lo < 32768) o.imm = lo;
    else o.imm = lo + 32'hFFFF_0000;
    o.jt = m_pcu * 32'h1000_0000 + (w % 32'h0400_0000) * 4;
    return o;
  endfunction

  task automatic driveInputs(input in_t v);
    reset           = v.rst;
    bus.instr_in    = v.instr;
    bus.pc_upper_in = v.pcu;
    bus.stall       = v.stall;
    bus.flush       = v.flush;
    bus.wb_we       = v.we;
    bus.wb_addr     = v.addr;
    bus.wb_data     = v.data;
  endtask

  // Drive one cycle of inputs, take the rising edge, and settle 1 unit past it.
  task automatic applyStimulus(input in_t v);
    driveInputs(v);
    @(posedge reloj);
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act.valid = bus.valid; act.opcode = bus.opcode; act.rs = bus.rs; act.rt = bus.rt;
    act.rd = bus.rd; act.shamt = bus.shamt; act.funct = bus.funct;
    act.rs_data = bus.rs_data; act.rt_data = bus.rt_data;
    act.imm = bus.imm_ext; act.jt = bus.jump_target;
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got v=%0d op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h rsd=%h rtd=%h imm=%h jt=%h ; want v=%0d op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h rsd=%h rtd=%h imm=%h jt=%h",
               name, act.valid, act.opcode, act.rs, act.rt, act.rd, act.shamt, act.funct,
               act.rs_data, act.rt_data, act.imm, act.jt,
               exp.valid, exp.opcode, exp.rs, exp.rt, exp.rd, exp.shamt, exp.funct,
               exp.rs_data, exp.rt_data, exp.imm, exp.jt);
    end
  endtask

  vec_t table_v [13];

  initial begin
    outs_t z;
    outs_t r0;
    outs_t rb;
    outs_t ori;
    outs_t jmp;
    in_t   v;
    vectors     = 0;
    miscompares = 0;
    driveInputs(mkIn(1'b1, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0));

    z   = mkOut(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 32'd0, 32'd0, 32'd0, 32'd0);
    r0  = mkOut(1'b1, 6'h08, 5'd9, 5'd8, 5'd31, 5'd31, 6'h3C, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h04A3_FFF0);
    rb  = r0; rb.rs_data = 32'hDEAD_BEEF;
    ori = mkOut(1'b1, 6'h0D, 5'd9, 5'd8, 5'd30, 5'd0, 6'h00, 32'd0, 32'd0, 32'h0000_F000, 32'h04A3_C000);
    jmp = mkOut(1'b1, 6'h02, 5'd0, 5'd16, 5'd0, 5'd0, 6'h04, 32'd0, 32'd0, 32'h0000_0004, 32'h4040_0010);

    table_v[0]  = '{mkIn(1, 32'h0000_0000, 4'h0, 0, 0, 0, 5'd0, 32'd0), z};
    table_v[1]  = '{mkIn(0, 32'h2128_FFFC, 4'h0, 0, 0, 0, 5'd0, 32'd0), r0};
    table_v[2]  = '{mkIn(0, 32'h3528_F000, 4'h0, 0, 0, 0, 5'd0, 32'd0), ori};
    table_v[3]  = '{mkIn(0, 32'h0810_0004, 4'h4, 0, 0, 0, 5'd0, 32'd0), jmp};
    table_v[4]  = '{mkIn(0, 32'h2128_FFFC, 4'h0, 0, 0, 0, 5'd0, 32'd0), r0};
    table_v[5]  = '{mkIn(0, 32'h3528_F000, 4'h0, 1, 0, 1, 5'd9, 32'hDEAD_BEEF), rb};
    table_v[6]  = '{mkIn(0, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 5'd0, 32'd0), rb};
    table_v[7]  = '{mkIn(0, 32'h0810_0004, 4'h4, 1, 0, 0, 5'd0, 32'd0), rb};
    table_v[8]  = '{mkIn(0, 32'h0810_0004, 4'h4, 0, 0, 1, 5'd0, 32'hFFFF_FFFF), jmp};
    table_v[9]  = '{mkIn(0, 32'h2128_FFFC, 4'h0, 1, 1, 0, 5'd0, 32'd0), z};
    table_v[10] = '{mkIn(0, 32'h2128_FFFC, 4'h0, 0, 0, 0, 5'd0, 32'd0), rb};
    table_v[11] = '{mkIn(1, 32'h3528_F000, 4'h0, 0, 0, 1, 5'd8, 32'h1111_1111), z};
    table_v[12] = '{mkIn(0, 32'h2128_FFFC, 4'h0, 0, 0, 0, 5'd0, 32'd0), r0};

    $display("[TB] directed table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(table_v[i].in);
      checkOutput($sformatf("table[%0d]", i), table_v[i].exp);
    end

    // Same-cycle bypass: change the write port mid-cycle, no clock edge in between.
    $display("[TB] bypass sequence");
    driveInputs(mkIn(0, 32'h0, 4'h0, 1, 0, 1, 5'd9, 32'hCAFE_F00D));
    #1;
    rb = r0; rb.rs_data = 32'hCAFE_F00D;
    checkOutput("bypass_rs", rb);
    driveInputs(mkIn(0, 32'h0, 4'h0, 1, 0, 1, 5'd8, 32'h0BAD_F00D));
    #1;
    rb = r0; rb.rt_data = 32'h0BAD_F00D;
    checkOutput("bypass_rt", rb);
    applyStimulus(mkIn(0, 32'h0, 4'h0, 1, 0, 1, 5'd8, 32'h0BAD_F00D));
    driveInputs(mkIn(0, 32'h0, 4'h0, 1, 0, 0, 5'd0, 32'd0));
    #1;
    checkOutput("array_rt_after_write", rb);

    // Fill every register, read one back, then reset and confirm all read zero.
    $display("[TB] reset-after-writes sequence");
    for (int a = 1; a < 32; a++) begin
      applyStimulus(mkIn(0, 32'h0, 4'h0, 1, 0, 1, 5'(a), 32'h5A5A_0000 + 32'(a)));
    end
    applyStimulus(mkIn(0, (32'd5 << 21) | (32'd31 << 16), 4'h0, 0, 0, 0, 5'd0, 32'd0));
    checkOutput("regs_before_reset",
                mkOut(1, 6'h00, 5'd5, 5'd31, 5'd0, 5'd0, 6'h00, 32'h5A5A_0005, 32'h5A5A_001F,
                      32'd0, ((32'd5 << 21) | (32'd31 << 16)) * 4));
    applyStimulus(mkIn(1, 32'h0, 4'h0, 0, 0, 0, 5'd0, 32'd0));
    checkOutput("mid_stream_reset", z);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = (32'(i) << 21) | (32'(31 - i) << 16);
      applyStimulus(mkIn(0, w, 4'h0, 0, 0, 0, 5'd0, 32'd0));
      checkOutput($sformatf("cleared_reg[%0d]", i),
                  mkOut(1, 6'h00, 5'(i), 5'(31 - i), 5'd0, 5'd0, 6'h00, 32'd0, 32'd0, 32'd0, w * 4));
    end

    // Randomized traffic against the behavioural model.
    $display("[TB] random phase");
    for (int n = 0; n < 400; n++) begin
      v.rst   = (n == 0) || ($urandom_range(63) == 0);
      v.instr = $urandom;
      if ($urandom_range(3) == 0) v.instr[31:26] = 6'(12 + $urandom_range(2));
      v.pcu   = 4'($urandom);
      v.stall = ($urandom_range(3) == 0);
      v.flush = ($urandom_range(7) == 0);
      v.we    = $urandom_range(1) == 1;
      v.addr  = ($urandom_range(3) == 0) ? v.instr[25:21] : 5'($urandom);
      v.data  = $urandom;
      applyStimulus(v);
      modelEdge(v);
      checkOutput($sformatf("random[%0d]", n), modelOut(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
